// File: rtl/bist_ctrl_gen.sv
// BIST controller: Galois LFSR pattern source and Galois MISR compactor around a CUT,
// with programmable pattern count, warm-up skip, abort and signature readout.
module bist_ctrl_gen #(
  parameter int unsigned    PI_W      = 35,
  parameter int unsigned    PO_W      = 49,
  parameter logic [PI_W-1:0] LFSR_POLY = PI_W'(35'h0_0000_0005),
  parameter logic [PI_W-1:0] LFSR_SEED = PI_W'(35'h1),
  parameter logic [PO_W-1:0] MISR_POLY = PO_W'(49'h0_0000_0000_0201),
  parameter int unsigned    NPAT      = 2000,
  parameter int unsigned    SKIP      = 0,
  parameter logic [PO_W-1:0] GOLDEN    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bistmode,
  input  logic [PI_W-1:0] pi,
  output logic [PI_W-1:0] cut_pi,
  input  logic [PO_W-1:0] cut_po,
  output logic [PO_W-1:0] po,
  output logic            bistdone,
  output logic            bistpass,
  output logic [PO_W-1:0] signature
);

  localparam int unsigned CNT_W = $clog2(NPAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [PI_W-1:0]   lfsr_q, lfsr_d, lfsr_nxt;
  logic [PO_W-1:0]   misr_q, misr_d, misr_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    cnt_inc;
  logic              misr_en;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  // Galois shift steps and warm-up gate (cnt >= SKIP written as cnt+1 > SKIP)
  assign lfsr_nxt = {lfsr_q[PI_W-2:0], 1'b0} ^ (lfsr_q[PI_W-1] ? LFSR_POLY : '0);
  assign misr_nxt = {misr_q[PO_W-2:0], 1'b0} ^ (misr_q[PO_W-1] ? MISR_POLY : '0) ^ cut_po;
  assign cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign misr_en  = cnt_inc > (CNT_W+1)'(SKIP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (bistmode) begin
          state_d = RUN;
          lfsr_d  = LFSR_SEED;
          misr_d  = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        // Abort wins over the terminal count; lfsr/misr keep their values
        if (!bistmode) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          lfsr_d = lfsr_nxt;
          if (misr_en) misr_d = misr_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NPAT - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (misr_d == GOLDEN);
          end
        end
      end
      DONE: begin
        if (!bistmode) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cut_pi    = (state_q == IDLE) ? pi : lfsr_q;
  assign po        = cut_po;
  assign bistdone  = done_q;
  assign bistpass  = pass_q;
  assign signature = misr_q;

endmodule

// File: tb/tb_bist_ctrl_gen.sv
// Self-checking bench for bist_ctrl_gen: directed sequence plus random CUT responses,
// checked against an arithmetic model of the LFSR/MISR rules.
module tb_bist_ctrl_gen;

  localparam int unsigned PI_W = 4;
  localparam int unsigned PO_W = 8;
  localparam int unsigned NPAT = 16;

  function automatic int lfsr_step(input int v);
    return ((v * 2) % 16) ^ ((v >= 8) ? 3 : 0);
  endfunction

  function automatic int misr_step(input int m, input int d);
    return ((m * 2) % 256) ^ ((m >= 128) ? 'h1D : 0) ^ (d % 256);
  endfunction

  // Signature of a stub CUT echoing its pattern (optionally with bit0 stuck at 1)
  function automatic int stub_sig(input int skip, input int nsamp, input int fault);
    int l;
    int m;
    l = 1;
    m = 0;
    for (int k = 0; k < nsamp; k++) begin
      if (k >= skip) m = misr_step(m, l | fault);
      l = lfsr_step(l);
    end
    return m;
  endfunction

  localparam logic [7:0] GOLD_A = 8'(stub_sig(0, 16, 0));
  localparam logic [7:0] GOLD_B = 8'(stub_sig(3, 16, 0));
  localparam logic [3:0] EXP_SEQ [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                                          4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

  logic       clk = 1'b0;
  logic       rst;
  logic       bm_a, bm_b;
  logic [3:0] pi_a, pi_b, cut_pi_a, cut_pi_b;
  logic [7:0] cut_po_a, cut_po_b, po_a, po_b, sig_a, sig_b;
  logic       done_a, done_b, pass_a, pass_b;
  logic       fault_a, inject_a, xmode_b;
  logic [7:0] rnd_a;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb cut_po_a = inject_a ? rnd_a : ({4'b0, cut_pi_a} | {7'b0, fault_a});
  always_comb cut_po_b = xmode_b ? 8'hxx : {4'b0, cut_pi_b};

  bist_ctrl_gen #(
    .PI_W(PI_W), .PO_W(PO_W), .LFSR_POLY(4'h3), .LFSR_SEED(4'h1), .MISR_POLY(8'h1D),
    .NPAT(NPAT), .SKIP(0), .GOLDEN(GOLD_A)
  ) u_a (
    .clk(clk), .rst(rst), .bistmode(bm_a), .pi(pi_a), .cut_pi(cut_pi_a), .cut_po(cut_po_a),
    .po(po_a), .bistdone(done_a), .bistpass(pass_a), .signature(sig_a)
  );

  bist_ctrl_gen #(
    .PI_W(PI_W), .PO_W(PO_W), .LFSR_POLY(4'h3), .LFSR_SEED(4'h1), .MISR_POLY(8'h1D),
    .NPAT(NPAT), .SKIP(3), .GOLDEN(GOLD_B)
  ) u_b (
    .clk(clk), .rst(rst), .bistmode(bm_b), .pi(pi_b), .cut_pi(cut_pi_b), .cut_po(cut_po_b),
    .po(po_b), .bistdone(done_b), .bistpass(pass_b), .signature(sig_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst  = 1'b1;
    bm_a = 1'b0;
    bm_b = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Full run on instance a from IDLE; edge 0 is the next edge
  task automatic run_a(input string tag, input int fault, input bit chk_seq);
    fault_a = fault[0];
    bm_a    = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (chk_seq) chk({tag, "_seq"}, cut_pi_a, EXP_SEQ[k]);
      chk({tag, "_busy"}, done_a, 1'b0);
      pi_a = 4'($urandom);
    end
    step();
    chk({tag, "_done"}, done_a, 1'b1);
    chk({tag, "_pass"}, pass_a, (fault == 0) ? 1'b1 : 1'b0);
    chk({tag, "_sig"}, sig_a, stub_sig(0, 16, fault));
    if (fault != 0) chk({tag, "_sig_ne_gold"}, sig_a != GOLD_A, 1'b1);
    step();
    chk({tag, "_hold_done"}, done_a, 1'b1);
    chk({tag, "_hold_sig"}, sig_a, stub_sig(0, 16, fault));
    chk({tag, "_frozen_lfsr"}, cut_pi_a, EXP_SEQ[1]);
    fault_a = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int m;
    rst = 1'b1; bm_a = 1'b0; bm_b = 1'b0;
    fault_a = 1'b0; inject_a = 1'b0; xmode_b = 1'b0; rnd_a = '0;
    pi_a = 4'($urandom); pi_b = 4'($urandom);

    // Reset values
    inject_a = 1'b1;
    repeat (3) begin
      rnd_a = 8'($urandom);
      pi_a  = 4'($urandom);
      pi_b  = 4'($urandom);
      step();
    end
    chk("rst_done", done_a, 1'b0);
    chk("rst_pass", pass_a, 1'b0);
    chk("rst_sig", sig_a, 8'h0);
    chk("rst_cut_pi", cut_pi_a, pi_a);
    chk("rst_po", po_a, rnd_a);
    chk("rst_done_b", done_b, 1'b0);
    chk("rst_sig_b", sig_b, 8'h0);
    chk("rst_cut_pi_b", cut_pi_b, pi_b);
    chk("rst_po_b", po_b, {4'b0, pi_b});
    inject_a = 1'b0;
    rst = 1'b0;

    // LFSR sequence, pass path, back-to-back repeat, fault detection
    run_a("pass1", 0, 1'b1);
    pulse_reset();
    chk("idle_sig", sig_a, 8'h0);
    chk("idle_done", done_a, 1'b0);
    run_a("pass2", 0, 1'b0);
    pulse_reset();
    run_a("fault", 1, 1'b0);
    pulse_reset();

    // Abort after 5 RUN edges, then a full rerun without reset
    bm_a = 1'b1;
    repeat (5) step();
    bm_a = 1'b0;
    pi_a = 4'($urandom);
    step();
    chk("abort_cut_pi", cut_pi_a, pi_a);
    chk("abort_done", done_a, 1'b0);
    chk("abort_sig", sig_a, stub_sig(0, 4, 0));
    step();
    chk("abort_done2", done_a, 1'b0);
    run_a("rerun", 0, 1'b0);

    // Random CUT responses
    repeat (3) begin
      pulse_reset();
      q.delete();
      inject_a = 1'b1;
      bm_a = 1'b1;
      step();
      for (int k = 0; k < 16; k++) begin
        rnd_a = 8'($urandom);
        q.push_back(int'(rnd_a));
        step();
      end
      m = 0;
      foreach (q[i]) m = misr_step(m, q[i]);
      chk("rand_done", done_a, 1'b1);
      chk("rand_sig", sig_a, m);
      chk("rand_pass", pass_a, (8'(m) == GOLD_A) ? 1'b1 : 1'b0);
      inject_a = 1'b0;
    end
    pulse_reset();

    // SKIP=3 with X responses during warm-up, then reset mid-run
    bm_b = 1'b1;
    xmode_b = 1'b1;
    step();
    for (int s = 1; s <= 6; s++) begin
      step();
      if (s == 3) xmode_b = 1'b0;
      chk("skip_sig", sig_b, stub_sig(3, s, 0));
    end
    rst = 1'b1;
    pi_b = 4'($urandom);
    step();
    chk("midrst_sig", sig_b, 8'h0);
    chk("midrst_done", done_b, 1'b0);
    chk("midrst_cut_pi", cut_pi_b, pi_b);
    rst = 1'b0;
    repeat (16) step();
    chk("skip_busy", done_b, 1'b0);
    step();
    chk("skip_done", done_b, 1'b1);
    chk("skip_pass", pass_b, 1'b1);
    chk("skip_sig_final", sig_b, GOLD_B);
    bm_b = 1'b0;
    step();
    chk("skip_exit_done", done_b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bist_ctrl_gen.md
# bist_ctrl_gen

Parametrised built-in self-test controller that wraps a combinational or sequential circuit-under-test (CUT) on the chip. In functional mode it passes primary inputs straight to the CUT. In BIST mode it drives the CUT from an internal Galois LFSR and compacts CUT outputs into a Galois MISR. After a programmable pattern count it reports `bistdone`/`bistpass` and exposes the final signature for golden extraction. It generalises the fixed-width 35-in/49-out BIST wrapper to arbitrary widths, polynomials, seeds, pattern counts and warm-up skip, and adds abort and signature readout.

## Interface
Parameters:
- `PI_W`, 35: CUT input width (≥2).
- `PO_W`, 49: CUT output width (≥2).
- `LFSR_POLY`, 35'h0_0000_0005: Galois feedback mask for the pattern generator.
- `LFSR_SEED`, 35'h1: LFSR start value. Must be non-zero.
- `MISR_POLY`, 49'h0_0000_0000_0201: Galois feedback mask for the compactor.
- `NPAT`, 2000: number of RUN cycles (≥1).
- `SKIP`, 0: number of initial RUN cycles with MISR update suppressed. Must satisfy `SKIP` < `NPAT`.
- `GOLDEN`, 49'h0: expected final signature.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset. The chip also routes it to the CUT.
- `bistmode`, in, 1: 1 = BIST, 0 = functional.
- `pi`, in, PI_W: functional primary inputs.
- `cut_pi`, out, PI_W: CUT inputs. Combinational mux: `pi` when state is IDLE, otherwise `lfsr`.
- `cut_po`, in, PO_W: CUT outputs.
- `po`, out, PO_W: equals `cut_po` in all states.
- `bistdone`, out, 1: registered. High only in DONE.
- `bistpass`, out, 1: registered. Valid when `bistdone`=1.
- `signature`, out, PO_W: current MISR value.

## Operation
- State machine has three states: IDLE, RUN, DONE.
- Registers: `state`, `lfsr[PI_W]`, `misr[PO_W]`, `cnt` of width $clog2(NPAT+1), `bistdone`, `bistpass`.
- Reset (`rst`=1 at an edge) sets: state=IDLE, `lfsr`=LFSR_SEED, `misr`=0, `cnt`=0, `bistdone`=0, `bistpass`=0. Reset overrides everything, including mid-RUN and DONE.
- IDLE:
  - If `bistmode`=1, go to RUN. `lfsr`=LFSR_SEED, `misr`=0, `cnt`=0.
  - Otherwise stay in IDLE.
- RUN, on each edge:
  - `lfsr` ← (`lfsr`<<1) ^ (`lfsr`[PI_W-1] ? LFSR_POLY : 0), truncated to PI_W.
  - `misr` ← (`misr`<<1) ^ (`misr`[PO_W-1] ? MISR_POLY : 0) ^ `cut_po`, truncated to PO_W. This update happens only when `cnt` ≥ SKIP; otherwise `misr` holds.
  - `cnt` ← `cnt`+1.
  - When `cnt` = NPAT-1: go to DONE. `bistdone` ← 1. `bistpass` ← (`misr_next` == GOLDEN), where `misr_next` is the value being written on that same edge.
- DONE: all registers hold. `lfsr` and `misr` are frozen.
- Abort: if `bistmode`=0 in RUN or DONE, go to IDLE with `bistdone`=0, `bistpass`=0, `cnt`=0. `misr` and `lfsr` retain their values. The abort check takes priority over the `cnt` terminal condition on the same edge.
- DONE exits only on `rst` or on `bistmode`=0. A new run therefore always restarts from LFSR_SEED with `misr`=0, so the signature is deterministic.

## Timing
- Edge numbering: edge 0 is the first edge with `rst`=0 and `bistmode`=1 in IDLE. Edge 0 enters RUN.
- The CUT sees patterns SEED, next(SEED), … during the cycles after edges 0, 1, …, NPAT-1.
- `cut_po` is sampled at edges 1…NPAT. The edge-k sample reflects the pattern applied after edge k-1.
- At edge NPAT: `bistdone`=1 and `bistpass` are valid together. Latency from edge 0 is NPAT+1 cycles.
- The `cut_pi` mux has zero-cycle latency on `state`. During the IDLE→RUN edge, `pi` is still applied to the CUT.
- The LFSR period is at most 2^PI_W−1. Wrap-around within NPAT is legal and simply repeats patterns.
- An X on `cut_po` during the first SKIP samples must not corrupt `misr`.

## Test plan
- Reset values: hold `rst`=1 for 3 cycles with random `pi`/`cut_po` → `bistdone`=0, `bistpass`=0, `signature`=0, `cut_pi`==`pi`.
- LFSR sequence: PI_W=4, LFSR_POLY=4'h3, SEED=4'h1, NPAT=16 → `cut_pi` after edges 0…15 reads 1,2,4,8,3,6,C,B,5,A,7,E,F,D,9,1 (wrap at pattern 15).
- Pass path: stub CUT `cut_po`=`cut_pi` zero-extended; compute the fault-free signature with a reference model and set GOLDEN to it → `bistdone` rises exactly NPAT+1 edges after `rst` falls, `bistpass`=1, `signature`==GOLDEN. Two back-to-back runs, each reset-separated, give identical results.
- Fault detection: same setup, force `cut_po[0]`=1 for the whole run → `bistdone`=1, `bistpass`=0, `signature`≠GOLDEN.
- Abort and re-run: drop `bistmode` at RUN cycle 5 → next edge state IDLE, `cut_pi`==`pi`, `bistdone` never asserted. Reassert `bistmode` → full run, `bistpass`=1.
- Reset mid-run and SKIP: SKIP=3, drive `cut_po`=X for the first 3 samples → `signature` unchanged from 0 until sample 4. Assert `rst` at cycle 7 → IDLE, `signature`=0, then a clean run passes.
